// File: rtl/mem_access_unit.sv
// Data-memory stage: one outstanding load/store with lane alignment, load extension and an ack timeout.
// Optional macro MEM_ALIGN_CHECK_EN rejects misaligned half/word accesses without issuing a bus request.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_in_valid,
    input  logic        i_mem_read_flag,
    input  logic        i_mem_write_flag,
    input  logic        i_mem_sign_ext_flag,
    input  logic [3:0]  i_mem_sel,
    input  logic [31:0] i_mem_write_data,
    input  logic [31:0] i_result,
    input  logic        i_reg_write_en,
    input  logic [4:0]  i_reg_write_addr,
    input  logic [31:0] i_current_pc_addr,
    output logic        o_stall_req,
    output logic        o_ram_en,
    output logic [3:0]  o_ram_write_en,
    output logic [31:0] o_ram_addr,
    output logic [31:0] o_ram_write_data,
    input  logic        i_ram_ack,
    input  logic [31:0] i_ram_read_data,
    output logic        o_out_valid,
    output logic [31:0] o_wb_data,
    output logic        o_wb_reg_write_en,
    output logic [4:0]  o_wb_reg_write_addr,
    output logic [31:0] o_wb_pc,
    output logic        o_bus_error,
    output logic        o_align_error
);
    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_accept;
    logic        w_complete;
    logic        w_timeout;
    logic        w_mem_op;
    logic        w_misalign;
    logic [3:0]  w_lanes;
    logic [31:0] w_lane_data;
    logic [31:0] w_shifted;
    logic [31:0] w_load_data;

    logic [15:0] r_timer;
    logic        r_is_store;
    logic        r_sign_ext;
    logic [3:0]  r_sel;
    logic [1:0]  r_off;
    logic        r_rd_en;
    logic [4:0]  r_rd_addr;
    logic [31:0] r_pc;

    logic        r_ram_en;
    logic [3:0]  r_ram_write_en;
    logic [31:0] r_ram_addr;
    logic [31:0] r_ram_write_data;
    logic        r_out_valid;
    logic [31:0] r_wb_data;
    logic        r_wb_reg_write_en;
    logic [4:0]  r_wb_reg_write_addr;
    logic [31:0] r_wb_pc;
    logic        r_bus_error;

    assign w_mem_op    = i_mem_read_flag | i_mem_write_flag;
    // Four-bit result drops lanes shifted past byte 3 on misaligned accesses.
    assign w_lanes     = i_mem_sel << i_result[1:0];
    assign w_lane_data = i_mem_write_data << {i_result[1:0], 3'b000};

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign = ((i_mem_sel == 4'b0011) && i_result[0]) ||
                        ((i_mem_sel == 4'b1111) && (i_result[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_complete  = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_in_valid) begin
                    w_accept = 1'b1;
                    if (w_mem_op && !w_misalign) begin
                        w_state_nxt = WAIT_ACK;
                    end
                end
            end
            WAIT_ACK: begin
                // Ack wins over the timeout when both land on the last allowed cycle.
                if (i_ram_ack) begin
                    w_complete  = 1'b1;
                    w_state_nxt = IDLE;
                end else if (r_timer == TIMEOUT_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_shifted = i_ram_read_data >> {r_off, 3'b000};

    always_comb begin
        w_load_data = w_shifted;
        case (r_sel)
            4'b0001: w_load_data = {{24{r_sign_ext & w_shifted[7]}}, w_shifted[7:0]};
            4'b0011: w_load_data = {{16{r_sign_ext & w_shifted[15]}}, w_shifted[15:0]};
            default: w_load_data = w_shifted;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_timer             <= 16'd0;
            r_is_store          <= 1'b0;
            r_sign_ext          <= 1'b0;
            r_sel               <= 4'd0;
            r_off               <= 2'd0;
            r_rd_en             <= 1'b0;
            r_rd_addr           <= 5'd0;
            r_pc                <= 32'd0;
            r_ram_en            <= 1'b0;
            r_ram_write_en      <= 4'd0;
            r_ram_addr          <= 32'd0;
            r_ram_write_data    <= 32'd0;
            r_out_valid         <= 1'b0;
            r_wb_data           <= 32'd0;
            r_wb_reg_write_en   <= 1'b0;
            r_wb_reg_write_addr <= 5'd0;
            r_wb_pc             <= 32'd0;
            r_bus_error         <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_bus_error <= 1'b0;
            if (w_accept) begin
                if (!w_mem_op || w_misalign) begin
                    r_out_valid         <= 1'b1;
                    r_wb_data           <= i_result;
                    r_wb_reg_write_en   <= i_reg_write_en & ~w_mem_op;
                    r_wb_reg_write_addr <= i_reg_write_addr;
                    r_wb_pc             <= i_current_pc_addr;
                end else begin
                    r_timer          <= 16'd0;
                    r_is_store       <= i_mem_write_flag;
                    r_sign_ext       <= i_mem_sign_ext_flag;
                    r_sel            <= i_mem_sel;
                    r_off            <= i_result[1:0];
                    r_rd_en          <= i_reg_write_en;
                    r_rd_addr        <= i_reg_write_addr;
                    r_pc             <= i_current_pc_addr;
                    r_ram_en         <= 1'b1;
                    r_ram_addr       <= {i_result[31:2], 2'b00};
                    r_ram_write_en   <= i_mem_write_flag ? w_lanes : 4'b0000;
                    r_ram_write_data <= i_mem_write_flag ? w_lane_data : 32'd0;
                end
            end
            if (w_complete || w_timeout) begin
                r_ram_en            <= 1'b0;
                r_ram_write_en      <= 4'b0000;
                r_out_valid         <= 1'b1;
                r_bus_error         <= w_timeout;
                r_wb_data           <= (w_complete && !r_is_store) ? w_load_data : 32'd0;
                r_wb_reg_write_en   <= w_complete & r_rd_en & ~r_is_store;
                r_wb_reg_write_addr <= r_rd_addr;
                r_wb_pc             <= r_pc;
            end else if (r_state == WAIT_ACK) begin
                r_timer <= r_timer + 16'd1;
            end
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic r_align_error;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_align_error <= 1'b0;
        end else begin
            r_align_error <= w_accept & w_mem_op & w_misalign;
        end
    end
    assign o_align_error = r_align_error;
`else
    assign o_align_error = 1'b0;
`endif

    assign o_stall_req         = (r_state == WAIT_ACK);
    assign o_ram_en            = r_ram_en;
    assign o_ram_write_en      = r_ram_write_en;
    assign o_ram_addr          = r_ram_addr;
    assign o_ram_write_data    = r_ram_write_data;
    assign o_out_valid         = r_out_valid;
    assign o_wb_data           = r_wb_data;
    assign o_wb_reg_write_en   = r_wb_reg_write_en;
    assign o_wb_reg_write_addr = r_wb_reg_write_addr;
    assign o_wb_pc             = r_wb_pc;
    assign o_bus_error         = r_bus_error;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit against a byte-level reference model; MEM_ALIGN_CHECK_EN selects the misalignment expectations.
`timescale 1ns/1ps
module tb_mem_access_unit;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, rd_f, wr_f, sx_f, rwe, ram_ack;
    logic [3:0]  sel;
    logic [31:0] wdata, result, pc, ram_rdata;
    logic [4:0]  rwa;
    logic        stall_req, ram_en, out_valid, wb_we, bus_error, align_error;
    logic [3:0]  ram_we;
    logic [31:0] ram_addr, ram_wd, wb_data, wb_pc;
    logic [4:0]  wb_addr;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] obs_ram_addr, obs_ram_wd, obs_wb_data;
    logic [3:0]  obs_ram_we;
    logic        obs_wb_we;
    int          obs_stall;

    mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid),
        .i_mem_read_flag(rd_f), .i_mem_write_flag(wr_f), .i_mem_sign_ext_flag(sx_f),
        .i_mem_sel(sel), .i_mem_write_data(wdata), .i_result(result),
        .i_reg_write_en(rwe), .i_reg_write_addr(rwa), .i_current_pc_addr(pc),
        .o_stall_req(stall_req), .o_ram_en(ram_en), .o_ram_write_en(ram_we),
        .o_ram_addr(ram_addr), .o_ram_write_data(ram_wd),
        .i_ram_ack(ram_ack), .i_ram_read_data(ram_rdata),
        .o_out_valid(out_valid), .o_wb_data(wb_data), .o_wb_reg_write_en(wb_we),
        .o_wb_reg_write_addr(wb_addr), .o_wb_pc(wb_pc),
        .o_bus_error(bus_error), .o_align_error(align_error)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic longint pow256(input int k);
        longint p = 1;
        for (int i = 0; i < k; i++) p = p * 256;
        return p;
    endfunction

    function automatic int sel_size(input logic [3:0] s);
        case (s)
            4'b0001: return 1;
            4'b0011: return 2;
            default: return 4;
        endcase
    endfunction

    // Byte lane b of the access lands in lane off+b; lanes past 3 fall off the bus.
    function automatic logic [3:0] exp_lanes(input int size, input int off);
        logic [3:0] l = 4'b0000;
        for (int b = 0; b < size; b++) if (off + b < 4) l[off+b] = 1'b1;
        return l;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [31:0] wd, input int off);
        longint v = longint'(wd) * pow256(off);
        return v[31:0];
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] rd, input int off, input int size, input logic sx);
        longint v = 0;
        for (int b = 0; b < size; b++)
            if (off + b < 4) v += ((longint'(rd) / pow256(off + b)) % 256) * pow256(b);
        if (sx && size < 4 && v >= pow256(size) / 2) v -= pow256(size);
        return v[31:0];
    endfunction

    task automatic run_op(input logic rd, input logic wr, input logic sx, input logic [3:0] s,
                          input logic [31:0] wd, input logic [31:0] adr, input logic we,
                          input logic [4:0] wa, input logic [31:0] p, input int ack_at,
                          input logic [31:0] rdat);
        logic is_mem, mis, tmo;
        int   size, off, waited;
        is_mem = rd | wr;
        size   = sel_size(s);
        off    = int'(adr[1:0]);
        mis    = (size == 2 && adr[0]) || (size == 4 && off != 0);
`ifndef MEM_ALIGN_CHECK_EN
        mis    = 1'b0;
`endif
        rd_f = rd; wr_f = wr; sx_f = sx; sel = s; wdata = wd; result = adr;
        rwe = we; rwa = wa; pc = p; in_valid = 1'b1;
        chk_eq("stall_at_issue", stall_req, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        obs_stall = 0;
        obs_ram_addr = ram_addr; obs_ram_we = ram_we; obs_ram_wd = ram_wd;
        if (!is_mem) begin
            chk_eq("alu_valid", out_valid, 1'b1);
            chk_eq("alu_data", wb_data, adr);
            chk_eq("alu_we", wb_we, we);
            chk_eq("alu_addr", wb_addr, wa);
            chk_eq("alu_pc", wb_pc, p);
            chk_eq("alu_stall", stall_req, 1'b0);
        end else if (mis) begin
            chk_eq("mis_ram_en", ram_en, 1'b0);
            chk_eq("mis_align_err", align_error, 1'b1);
            chk_eq("mis_valid", out_valid, 1'b1);
            chk_eq("mis_we", wb_we, 1'b0);
            chk_eq("mis_stall", stall_req, 1'b0);
        end else begin
            chk_eq("req_ram_en", ram_en, 1'b1);
            chk_eq("req_ram_addr", ram_addr, {adr[31:2], 2'b00});
            chk_eq("req_ram_we", ram_we, wr ? exp_lanes(size, off) : 4'b0000);
            if (wr) chk_eq("req_ram_wd", ram_wd, exp_wdata(wd, off));
            chk_eq("req_valid", out_valid, 1'b0);
            waited = 0;
            tmo    = 1'b0;
            while (1) begin
                waited++;
                if (stall_req) obs_stall++;
                chk_eq("wait_stall", stall_req, 1'b1);
                chk_eq("wait_ram_en", ram_en, 1'b1);
                chk_eq("wait_ram_addr", ram_addr, obs_ram_addr);
                if (waited == ack_at) begin
                    ram_ack = 1'b1; ram_rdata = rdat;
                end
                @(posedge clk); #1;
                ram_ack = 1'b0; ram_rdata = $urandom;
                if (waited == ack_at) break;
                if (waited >= TO) begin tmo = 1'b1; break; end
            end
            chk_eq("done_valid", out_valid, 1'b1);
            chk_eq("done_bus_err", bus_error, tmo);
            chk_eq("done_ram_en", ram_en, 1'b0);
            chk_eq("done_stall", stall_req, 1'b0);
            chk_eq("done_we", wb_we, (tmo || wr) ? 1'b0 : we);
            chk_eq("done_addr", wb_addr, wa);
            chk_eq("done_pc", wb_pc, p);
            if (!tmo && !wr) chk_eq("load_data", wb_data, exp_load(rdat, off, size, sx));
        end
        obs_wb_data = wb_data;
        obs_wb_we   = wb_we;
        @(posedge clk); #1;
        chk_eq("pulse_valid_drop", out_valid, 1'b0);
        chk_eq("pulse_bus_drop", bus_error, 1'b0);
        chk_eq("pulse_align_drop", align_error, 1'b0);
    endtask

    initial begin
        logic [3:0]  s;
        int          kind, ack_at;
        rst = 1'b1; in_valid = 1'b0; rd_f = 1'b0; wr_f = 1'b0; sx_f = 1'b0; sel = 4'd0;
        wdata = 32'd0; result = 32'd0; rwe = 1'b0; rwa = 5'd0; pc = 32'd0;
        ram_ack = 1'b0; ram_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_eq("rst_ram_en", ram_en, 1'b0);
        chk_eq("rst_ram_we", ram_we, 4'b0000);
        chk_eq("rst_ram_addr", ram_addr, 32'd0);
        chk_eq("rst_ram_wd", ram_wd, 32'd0);
        chk_eq("rst_valid", out_valid, 1'b0);
        chk_eq("rst_wb_data", wb_data, 32'd0);
        chk_eq("rst_wb_we", wb_we, 1'b0);
        chk_eq("rst_wb_pc", wb_pc, 32'd0);
        chk_eq("rst_stall", stall_req, 1'b0);
        chk_eq("rst_errs", {bus_error, align_error}, 2'b00);
        rst = 1'b0;

        run_op(1'b0, 1'b0, 1'b0, 4'b1111, 32'd0, 32'h1234, 1'b1, 5'd5, 32'h100, 0, 32'd0);
        chk_eq("alu_wb_data", obs_wb_data, 32'h00001234);

        run_op(1'b1, 1'b0, 1'b1, 4'b0001, 32'd0, 32'h1002, 1'b1, 5'd7, 32'h104, 3, 32'h00800000);
        chk_eq("lb_ram_addr", obs_ram_addr, 32'h1000);
        chk_eq("lb_stall_cycles", obs_stall, 3);
        chk_eq("lb_wb_data", obs_wb_data, 32'hFFFFFF80);

        run_op(1'b0, 1'b1, 1'b0, 4'b0011, 32'h0000BEEF, 32'h2002, 1'b1, 5'd9, 32'h108, 1, 32'd0);
        chk_eq("sh_ram_we", obs_ram_we, 4'b1100);
        chk_eq("sh_ram_wd", obs_ram_wd, 32'hBEEF0000);
        chk_eq("sh_wb_we", obs_wb_we, 1'b0);

        run_op(1'b1, 1'b0, 1'b0, 4'b1111, 32'd0, 32'h3000, 1'b1, 5'd3, 32'h10C, -1, 32'd0);
        chk_eq("tmo_stall_cycles", obs_stall, TO);
        run_op(1'b0, 1'b0, 1'b0, 4'b1111, 32'd0, 32'h55AA, 1'b1, 5'd6, 32'h110, 0, 32'd0);
        chk_eq("after_tmo_alu", obs_wb_data, 32'h000055AA);

        run_op(1'b1, 1'b0, 1'b0, 4'b1111, 32'd0, 32'h4000, 1'b1, 5'd4, 32'h114, TO, 32'hCAFEF00D);
        chk_eq("last_cycle_ack", obs_wb_data, 32'hCAFEF00D);

        rd_f = 1'b1; wr_f = 1'b0; sel = 4'b1111; result = 32'h5000; rwe = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk_eq("rst_wait_stall", stall_req, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_eq("rst_wait_ram_en", ram_en, 1'b0);
        chk_eq("rst_wait_valid", out_valid, 1'b0);
        chk_eq("rst_wait_stall_drop", stall_req, 1'b0);
        ram_ack = 1'b1;
        @(posedge clk); #1;
        ram_ack = 1'b0;
        chk_eq("late_ack_valid", out_valid, 1'b0);
        chk_eq("late_ack_ram_en", ram_en, 1'b0);

`ifdef MEM_ALIGN_CHECK_EN
        run_op(1'b1, 1'b0, 1'b0, 4'b1111, 32'd0, 32'h1001, 1'b1, 5'd8, 32'h118, 1, 32'd0);
        chk_eq("align_wb_we", obs_wb_we, 1'b0);
`else
        run_op(1'b0, 1'b1, 1'b0, 4'b1111, 32'h11223344, 32'h1003, 1'b0, 5'd8, 32'h118, 2, 32'd0);
        chk_eq("trunc_lanes", obs_ram_we, 4'b1000);
        chk_eq("trunc_wd", obs_ram_wd, 32'h44000000);
`endif

        for (int it = 0; it < 200; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                ram_ack = 1'b1;
                @(posedge clk); #1;
                ram_ack = 1'b0;
                chk_eq("idle_ack_ram_en", ram_en, 1'b0);
                chk_eq("idle_ack_valid", out_valid, 1'b0);
            end
            kind = $urandom_range(0, 3);
            case ($urandom_range(0, 2))
                0:       s = 4'b0001;
                1:       s = 4'b0011;
                default: s = 4'b1111;
            endcase
            ack_at = ($urandom_range(0, 5) == 0) ? -1 : $urandom_range(1, TO);
            run_op(kind == 1 || kind == 3, kind == 2 || kind == 3, 1'($urandom), s,
                   $urandom, $urandom, 1'($urandom), 5'($urandom), $urandom, ack_at, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum cycles to wait for ram_ack before aborting an access (range 1..65535).
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 in_valid  in  1  EX presents a valid instruction.
REQ-005 mem_read_flag / mem_write_flag / mem_sign_ext_flag  in  1 each  load / store / load sign-extension control from EX.
REQ-006 mem_sel  in  4  access size: 0001 byte, 0011 half, 1111 word, unshifted.
REQ-007 mem_write_data  in  32  store data, right-aligned.
REQ-008 result  in  32  ALU result; this is the byte address for memory ops.
REQ-009 reg_write_en / reg_write_addr / current_pc_addr  in  1/5/32  writeback controls and PC from EX.
REQ-010 stall_req  out  1  EX shall hold its outputs while this is high.
REQ-011 ram_en / ram_write_en / ram_addr / ram_write_data  out  1/4/32/32  data-bus request, byte-lane write enables, word-aligned address, lane-aligned data.
REQ-012 ram_ack / ram_read_data  in  1/32  bus completion pulse and read word.
REQ-013 out_valid / wb_data / wb_reg_write_en / wb_reg_write_addr / wb_pc  out  1/32/1/5/32  registered results to WB.
REQ-014 bus_error / align_error  out  1 each  one-cycle error pulses.

Function
REQ-015 States: IDLE, WAIT_ACK. An instruction is accepted when in_valid=1 and state=IDLE.
REQ-016 A non-memory instruction accepted in IDLE appears on the WB outputs the next cycle, with out_valid=1, wb_data=result, and the writeback controls passed through.
REQ-017 A load or store accepted in IDLE moves the block to WAIT_ACK, registering ram_en=1, ram_addr={result[31:2],2'b00}, and lanes = mem_sel << result[1:0].
REQ-018 For a store, ram_write_en=lanes and ram_write_data=mem_write_data << (8*result[1:0]); for a load, ram_write_en=0000.
REQ-019 In WAIT_ACK, all ram_* outputs shall hold stable and stall_req=1 (combinational from state).
REQ-020 ram_ack sampled high in WAIT_ACK completes the access: next cycle ram_en=0, state=IDLE, out_valid=1.
REQ-021 Load data = (ram_read_data >> 8*result[1:0]) masked to the access size, then sign-extended if mem_sign_ext_flag=1, else zero-extended; this value drives wb_data.
REQ-022 A store shall force wb_reg_write_en=0.
REQ-023 A timeout counter starts at 0 on entry to WAIT_ACK and increments each cycle without ack.
REQ-024 Ack arriving in the same cycle the counter reaches TIMEOUT_CYCLES-1 counts as success.
REQ-025 If the counter reaches TIMEOUT_CYCLES-1 without ack, the access aborts: ram_en=0, bus_error=1 for one cycle, out_valid=1 with wb_reg_write_en=0, state=IDLE.
REQ-026 ram_ack while in IDLE shall be ignored.
REQ-027 out_valid and the error pulses shall be high for exactly one cycle per instruction; with no new accept the next cycle, they drop to 0.
REQ-028 A load and a store flag both set shall be treated as a store.

Reset
REQ-029 On rst: state=IDLE, counter=0, and ram_en, ram_write_en, ram_addr, ram_write_data, out_valid, wb_*, bus_error and align_error all 0.
REQ-030 rst asserted during WAIT_ACK abandons the access with no out_valid; an ack arriving after reset is ignored.

Configuration
REQ-031 Macro MEM_ALIGN_CHECK_EN, when defined: a half access with result[0]=1, or a word access with result[1:0]!=00, issues no bus request, pulses align_error next cycle, sets out_valid=1 and wb_reg_write_en=0, and stays in IDLE.
REQ-032 Without MEM_ALIGN_CHECK_EN: align_error is tied to 0, misaligned accesses proceed per REQ-017, and lanes above bit 3 are truncated.

Verification
REQ-033 ALU op result=0x1234, reg_write_en=1, addr=5 -> next cycle out_valid=1, wb_data=0x00001234, wb_reg_write_addr=5, stall_req never high.
REQ-034 Byte load, sign-ext, result=0x1002, read data 0x00800000 with ack after 3 cycles -> ram_addr=0x1000, stall_req high 3 cycles, wb_data=0xFFFFFF80.
REQ-035 Half store, result=0x2002, data 0xBEEF -> ram_write_en=1100, ram_write_data=0xBEEF0000, wb_reg_write_en=0.
REQ-036 TIMEOUT_CYCLES=4 with no ack -> bus_error pulses after 4 WAIT_ACK cycles, block back in IDLE, a following ALU op completes normally.
REQ-037 rst pulse in WAIT_ACK followed by a late ack -> no out_valid, ram_en=0 after reset.
REQ-038 With MEM_ALIGN_CHECK_EN, word load at 0x1001 -> ram_en stays 0, align_error=1 for one cycle, wb_reg_write_en=0.
